// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with flop-array storage, selectable registered or FWFT read,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module fifo_sync_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 64,
    parameter bit          FWFT     = 1'b0,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       winc,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       wfull,
    output logic                       walmost_full,
    input  logic                       rinc,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rempty,
    output logic                       ralmost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic [AW:0] count_w;
    logic        wr_en;
    logic        rd_en;

    // Status is decoded purely from registered pointers; wrap bit disambiguates full/empty.
    assign count_w       = wptr_q - rptr_q;
    assign count         = count_w;
    assign wfull         = (count_w == DEPTH_C);
    assign rempty        = (count_w == '0);
    assign walmost_full  = (count_w >= AF_C);
    assign ralmost_empty = (count_w <= AE_C);
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    assign wr_en = winc && !wfull  && !clear;
    assign rd_en = rinc && !rempty && !clear;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en) wptr_d = wptr_q + ONE_C;
            if (rd_en) rptr_d = rptr_q + ONE_C;
            if (winc && wfull)  overflow_d  = 1'b1;
            if (rinc && rempty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally left out of reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    if (FWFT) begin : g_fwft
        assign rdata = mem_q[rptr_q[AW-1:0]];
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (clear)      rdata_d = '0;
            else if (rd_en) rdata_d = mem_q[rptr_q[AW-1:0]];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rdata_q <= '0;
            else        rdata_q <= rdata_d;
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a DEPTH=8 standard-read instance and a DEPTH=4 FWFT instance.
module tb_fifo_sync_param;

    logic clk;
    logic rst_n;

    logic       s_clear, s_winc, s_rinc;
    logic [7:0] s_wdata, s_rdata;
    logic       s_wfull, s_walmost_full, s_rempty, s_ralmost_empty, s_overflow, s_underflow;
    logic [3:0] s_count;

    logic       f_clear, f_winc, f_rinc;
    logic [7:0] f_wdata, f_rdata;
    logic       f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
    logic [2:0] f_count;

    int checks = 0;
    int errors = 0;

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .FWFT(1'b0), .AF_LEVEL(4), .AE_LEVEL(4)) u_std (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .winc(s_winc), .wdata(s_wdata),
        .wfull(s_wfull), .walmost_full(s_walmost_full), .rinc(s_rinc), .rdata(s_rdata),
        .rempty(s_rempty), .ralmost_empty(s_ralmost_empty), .count(s_count),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .FWFT(1'b1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clear(f_clear), .winc(f_winc), .wdata(f_wdata),
        .wfull(f_wfull), .walmost_full(f_walmost_full), .rinc(f_rinc), .rdata(f_rdata),
        .rempty(f_rempty), .ralmost_empty(f_ralmost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        s_clear = 1'b1; s_winc = 1'b0; s_rinc = 1'b0;
        step();
        s_clear = 1'b0;
    endtask

    task automatic fill_std(input logic [7:0] base, input int n);
        for (int i = 1; i <= n; i++) begin
            s_winc = 1'b1; s_wdata = base + 8'(i);
            step();
        end
        s_winc = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_clear = 0; s_winc = 0; s_rinc = 0; s_wdata = 0;
        f_clear = 0; f_winc = 0; f_rinc = 0; f_wdata = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b expected 1", s_rempty); end
        checks++; if (s_wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %b expected 0", s_wfull); end
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", s_count); end
        checks++; if (s_ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_ralmost_empty: got %b expected 1", s_ralmost_empty); end
        checks++; if (s_walmost_full !== 1'b0) begin errors++; $display("FAIL reset_walmost_full: got %b expected 0", s_walmost_full); end
        checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", s_rdata); end
        checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", s_overflow); end
        checks++; if (s_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", s_underflow); end
        checks++; if (f_rempty !== 1'b1) begin errors++; $display("FAIL reset_fwft_rempty: got %b expected 1", f_rempty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            s_winc = 1'b1; s_wdata = 8'(i);
            step();
            checks++; if (s_count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, s_count, i); end
            checks++; if (s_wfull !== (i == 8)) begin errors++; $display("FAIL fill_wfull[%0d]: got %b expected %b", i, s_wfull, (i == 8)); end
            checks++; if (s_walmost_full !== (i >= 4)) begin errors++; $display("FAIL fill_walmost_full[%0d]: got %b expected %b", i, s_walmost_full, (i >= 4)); end
            checks++; if (s_ralmost_empty !== (i <= 4)) begin errors++; $display("FAIL fill_ralmost_empty[%0d]: got %b expected %b", i, s_ralmost_empty, (i <= 4)); end
        end
        s_winc = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_rinc = 1'b1;
            step();
            checks++; if (s_rdata !== 8'(i)) begin errors++; $display("FAIL drain_rdata[%0d]: got %h expected %h", i, s_rdata, 8'(i)); end
            checks++; if (s_count !== 4'(8 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, s_count, 8 - i); end
            if (i == 1) begin
                checks++; if (s_wfull !== 1'b0) begin errors++; $display("FAIL drain_wfull_release: got %b expected 0", s_wfull); end
            end
        end
        s_rinc = 1'b0;
        checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty: got %b expected 1", s_rempty); end
        checks++; if (s_underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow: got %b expected 0", s_underflow); end
        checks++; if (s_rdata !== 8'h08) begin errors++; $display("FAIL drain_rdata_hold: got %h expected 08", s_rdata); end
    endtask

    task automatic test_overflow_clear();
        fill_std(8'h10, 8);
        s_winc = 1'b1; s_wdata = 8'hFF;
        step();
        s_winc = 1'b0;
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", s_overflow); end
        checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", s_count); end
        step();
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", s_overflow); end
        for (int i = 1; i <= 8; i++) begin
            s_rinc = 1'b1;
            step();
            checks++; if (s_rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_readout[%0d]: got %h expected %h", i, s_rdata, 8'h10 + 8'(i)); end
        end
        s_rinc = 1'b0;
        fill_std(8'h30, 3);
        pulse_clear();
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", s_count); end
        checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b expected 0", s_overflow); end
        checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL clear_rempty: got %b expected 1", s_rempty); end
        checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL clear_rdata: got %h expected 00", s_rdata); end
    endtask

    task automatic test_simultaneous();
        fill_std(8'h20, 8);
        s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'hEE;
        step();
        s_winc = 1'b0; s_rinc = 1'b0;
        checks++; if (s_count !== 4'd7) begin errors++; $display("FAIL full_rw_count: got %0d expected 7", s_count); end
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL full_rw_overflow: got %b expected 1", s_overflow); end
        checks++; if (s_rdata !== 8'h21) begin errors++; $display("FAIL full_rw_rdata: got %h expected 21", s_rdata); end
        pulse_clear();
        s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'h77;
        step();
        s_winc = 1'b0; s_rinc = 1'b0;
        checks++; if (s_count !== 4'd1) begin errors++; $display("FAIL empty_rw_count: got %0d expected 1", s_count); end
        checks++; if (s_underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_underflow: got %b expected 1", s_underflow); end
        checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL empty_rw_no_bypass: got %h expected 00", s_rdata); end
        s_rinc = 1'b1;
        step();
        s_rinc = 1'b0;
        checks++; if (s_rdata !== 8'h77) begin errors++; $display("FAIL empty_rw_readback: got %h expected 77", s_rdata); end
        // clear wins over requests and raises no error flag
        s_clear = 1'b1; s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'h99;
        step();
        s_clear = 1'b0; s_winc = 1'b0; s_rinc = 1'b0;
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL clear_prio_count: got %0d expected 0", s_count); end
        checks++; if ({s_overflow, s_underflow} !== 2'b00) begin errors++; $display("FAIL clear_prio_flags: got %b expected 00", {s_overflow, s_underflow}); end
    endtask

    task automatic test_fwft();
        f_winc = 1'b1; f_wdata = 8'hA5;
        step();
        checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_first_rdata: got %h expected a5", f_rdata); end
        checks++; if (f_rempty !== 1'b0) begin errors++; $display("FAIL fwft_first_rempty: got %b expected 0", f_rempty); end
        f_wdata = 8'h5A;
        step();
        f_winc = 1'b0;
        checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_head_hold: got %h expected a5", f_rdata); end
        f_rinc = 1'b1;
        step();
        f_rinc = 1'b0;
        checks++; if (f_rdata !== 8'h5A) begin errors++; $display("FAIL fwft_pop_rdata: got %h expected 5a", f_rdata); end
        checks++; if (f_count !== 3'd1) begin errors++; $display("FAIL fwft_pop_count: got %0d expected 1", f_count); end
        for (int i = 0; i < 3; i++) begin
            f_winc = 1'b1; f_wdata = 8'hC0 + 8'(i);
            step();
        end
        f_winc = 1'b0;
        checks++; if (f_wfull !== 1'b1) begin errors++; $display("FAIL fwft_wfull: got %b expected 1", f_wfull); end
        checks++; if (f_count !== 3'd4) begin errors++; $display("FAIL fwft_full_count: got %0d expected 4", f_count); end
        checks++; if (f_rdata !== 8'h5A) begin errors++; $display("FAIL fwft_full_head: got %h expected 5a", f_rdata); end
    endtask

    task automatic test_stream();
        logic [7:0] q[$];
        logic [7:0] exp;
        int nw = 0;
        int nr = 0;
        int cyc = 0;
        logic w, r;
        pulse_clear();
        while ((nw < 40 || nr < 40) && cyc < 2000) begin
            w = ($urandom_range(0, 1) == 1) && (q.size() < 8) && (nw < 40);
            r = ($urandom_range(0, 1) == 1) && (q.size() > 0);
            s_winc = w; s_rinc = r; s_wdata = 8'(8'h40 + nw);
            step();
            cyc++;
            if (r) begin
                exp = q.pop_front();
                nr++;
                checks++; if (s_rdata !== exp) begin errors++; $display("FAIL stream_rdata[%0d]: got %h expected %h", nr, s_rdata, exp); end
            end
            if (w) begin
                q.push_back(8'(8'h40 + nw));
                nw++;
            end
            checks++; if (s_count !== 4'(nw - nr)) begin errors++; $display("FAIL stream_count[cyc %0d]: got %0d expected %0d", cyc, s_count, nw - nr); end
        end
        s_winc = 1'b0; s_rinc = 1'b0;
        checks++; if (nr != 40) begin errors++; $display("FAIL stream_budget: got %0d reads expected 40", nr); end
        checks++; if ({s_overflow, s_underflow} !== 2'b00) begin errors++; $display("FAIL stream_flags: got %b expected 00", {s_overflow, s_underflow}); end
        checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL stream_rempty: got %b expected 1", s_rempty); end
    endtask

    task automatic test_async_reset();
        fill_std(8'h50, 3);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", s_count); end
        checks++; if (s_rempty !== 1'b1) begin errors++; $display("FAIL async_reset_rempty: got %b expected 1", s_rempty); end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_clear();
        test_simultaneous();
        test_fwft();
        test_stream();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
